// File: rtl/fddplay_if.sv
// DMA byte channel between the DMA engine and the fddplay write-data generator.
// The master side presents RLE bytes; the slave side accepts them and signals terminate.
interface fddplay_if;
    logic [7:0] data;
    logic       req;
    logic       stb;
    logic       stop;

    modport master (output data, req, input stb, stop);
    modport slave  (input data, req, output stb, stop);
endinterface

// File: rtl/fddplay.sv
// RLE-to-MFM write-data generator: each accepted byte N sets a 2N-cycle interval
// that ends in a PW-cycle active-low pulse on wdat_n (N=0 is a silent 512-cycle gap).
module fddplay #(
    parameter int unsigned PW = 4
) (
    input  logic        clk,
    input  logic        reset,
    fddplay_if.slave    dma,
    output logic        wdat_n,
    output logic        wgate,
    output logic        underrun,
    input  logic        cnt_latch,
    output logic [18:0] data_cnt_l
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] UNDER = 2'd2;

    localparam logic [3:0] PW_M1 = 4'(PW - 1);

    logic [1:0]  state;
    logic [7:0]  cur;
    logic [7:0]  nxt;
    logic        nxt_valid;
    logic [8:0]  ic;
    logic [3:0]  pc;
    logic [18:0] data_cnt;
    logic        reset_r;

    // Terminal cycle is ic==0, so a 2N-cycle interval loads 2N-1.
    function automatic logic [8:0] load_val(input logic [7:0] n);
        return (n == 8'd0) ? 9'd511 : ({1'b0, n} << 1) - 9'd1;
    endfunction

    assign dma.stb  = reset && dma.req && !nxt_valid && (state != UNDER);
    assign dma.stop = !reset && reset_r;
    assign wgate    = (state == RUN);

    always_ff @(posedge clk) begin
        reset_r <= reset;
        if (cnt_latch) begin
            data_cnt_l <= data_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cur       <= 8'd0;
            nxt_valid <= 1'b0;
            ic        <= 9'd0;
            pc        <= 4'd0;
            wdat_n    <= 1'b1;
            underrun  <= 1'b0;
            data_cnt  <= 19'd0;
        end else begin
            if (!wdat_n) begin
                if (pc == 4'd0) begin
                    wdat_n <= 1'b1;
                end else begin
                    pc <= pc - 4'd1;
                end
            end

            if (dma.stb) begin
                nxt       <= dma.data;
                nxt_valid <= 1'b1;
                data_cnt  <= data_cnt + 19'd1;
            end

            case (state)
                IDLE: begin
                    if (nxt_valid) begin
                        cur       <= nxt;
                        ic        <= load_val(nxt);
                        nxt_valid <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (ic == 9'd0) begin
                        // A pulse starting over an active one restarts pc, merging them.
                        if (cur != 8'd0) begin
                            wdat_n <= 1'b0;
                            pc     <= PW_M1;
                        end
                        if (nxt_valid) begin
                            cur       <= nxt;
                            ic        <= load_val(nxt);
                            nxt_valid <= 1'b0;
                        end else begin
                            underrun <= 1'b1;
                            state    <= UNDER;
                        end
                    end else begin
                        ic <= ic - 9'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
